// File: rtl/decoder.sv
// RV32I instruction decoder: combinational field/immediate/control decode
// plus a registered sticky halt flag that is set by ECALL.
module decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir,
  output logic [4:0]  srcreg1_num,
  output logic [4:0]  srcreg2_num,
  output logic [4:0]  dstreg_num,
  output logic [31:0] imm,
  output logic [5:0]  alucode,
  output logic [1:0]  aluop1_type,
  output logic [1:0]  aluop2_type,
  output logic        reg_we,
  output logic        is_load,
  output logic        is_store,
  output logic        is_halt
);

  // ALU operation codes (define.vh numbering)
  localparam logic [5:0] ALU_LUI  = 6'd0,  ALU_JAL  = 6'd1,  ALU_JALR = 6'd2;
  localparam logic [5:0] ALU_BEQ  = 6'd3,  ALU_BNE  = 6'd4,  ALU_BLT  = 6'd5;
  localparam logic [5:0] ALU_BGE  = 6'd6,  ALU_BLTU = 6'd7,  ALU_BGEU = 6'd8;
  localparam logic [5:0] ALU_LB   = 6'd9,  ALU_LH   = 6'd10, ALU_LW   = 6'd11;
  localparam logic [5:0] ALU_LBU  = 6'd12, ALU_LHU  = 6'd13, ALU_SB   = 6'd14;
  localparam logic [5:0] ALU_SH   = 6'd15, ALU_SW   = 6'd16, ALU_ADD  = 6'd17;
  localparam logic [5:0] ALU_SUB  = 6'd18, ALU_XOR  = 6'd19, ALU_OR   = 6'd20;
  localparam logic [5:0] ALU_AND  = 6'd21, ALU_SLT  = 6'd22, ALU_SLTU = 6'd23;
  localparam logic [5:0] ALU_SLL  = 6'd24, ALU_SRL  = 6'd25, ALU_SRA  = 6'd26;
  localparam logic [5:0] ALU_NOP  = 6'd63;

  localparam logic [1:0] OP_TYPE_NONE = 2'd0, OP_TYPE_REG = 2'd1;
  localparam logic [1:0] OP_TYPE_IMM  = 2'd2, OP_TYPE_PC  = 2'd3;

  localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111, OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011, OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [4:0]  rs1_s, rs2_s, rd_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s, imm_sh_s;
  logic        legal_s, writes_s;
  logic        halt_q, halt_d;

  assign opcode_s = ir[6:0];
  assign funct3_s = ir[14:12];
  assign rs1_s    = ir[19:15];
  assign rs2_s    = ir[24:20];
  assign rd_s     = ir[11:7];
  assign imm_i_s  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b_s  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u_s  = {ir[31:12], 12'h000};
  assign imm_j_s  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_sh_s = {27'd0, ir[24:20]};

  // Decode opcode/funct3 into fields and controls; illegal encodings collapse to a NOP
  always_comb begin
    srcreg1_num = 5'd0;
    srcreg2_num = 5'd0;
    dstreg_num  = 5'd0;
    imm         = 32'd0;
    alucode     = ALU_NOP;
    aluop1_type = OP_TYPE_NONE;
    aluop2_type = OP_TYPE_NONE;
    is_load     = 1'b0;
    is_store    = 1'b0;
    legal_s     = 1'b1;
    writes_s    = 1'b0;
    case (opcode_s)
      OPC_OP, OPC_OPIMM: begin
        srcreg1_num = rs1_s;
        dstreg_num  = rd_s;
        aluop1_type = OP_TYPE_REG;
        writes_s    = 1'b1;
        if (opcode_s == OPC_OP) begin
          srcreg2_num = rs2_s;
          aluop2_type = OP_TYPE_REG;
        end else begin
          imm         = imm_i_s;
          aluop2_type = OP_TYPE_IMM;
        end
        case (funct3_s)
          3'b000: alucode = (opcode_s == OPC_OP && ir[30]) ? ALU_SUB : ALU_ADD;
          3'b001: alucode = ALU_SLL;
          3'b010: alucode = ALU_SLT;
          3'b011: alucode = ALU_SLTU;
          3'b100: alucode = ALU_XOR;
          3'b101: alucode = ir[30] ? ALU_SRA : ALU_SRL;
          3'b110: alucode = ALU_OR;
          default: alucode = ALU_AND;
        endcase
        // Immediate shifts carry a zero-extended shamt, not an I-type immediate
        if (opcode_s == OPC_OPIMM && (funct3_s == 3'b001 || funct3_s == 3'b101)) begin
          imm = imm_sh_s;
        end else begin
          imm = imm;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        dstreg_num = rd_s;
        imm        = imm_u_s;
        writes_s   = 1'b1;
        if (opcode_s == OPC_LUI) begin
          alucode     = ALU_LUI;
          aluop1_type = OP_TYPE_NONE;
          aluop2_type = OP_TYPE_IMM;
        end else begin
          alucode     = ALU_ADD;
          aluop1_type = OP_TYPE_IMM;
          aluop2_type = OP_TYPE_PC;
        end
      end
      OPC_LOAD: begin
        srcreg1_num = rs1_s;
        dstreg_num  = rd_s;
        imm         = imm_i_s;
        aluop1_type = OP_TYPE_REG;
        aluop2_type = OP_TYPE_IMM;
        is_load     = 1'b1;
        writes_s    = 1'b1;
        case (funct3_s)
          3'b000:  alucode = ALU_LB;
          3'b001:  alucode = ALU_LH;
          3'b010:  alucode = ALU_LW;
          3'b100:  alucode = ALU_LBU;
          3'b101:  alucode = ALU_LHU;
          default: legal_s = 1'b0;
        endcase
      end
      OPC_STORE: begin
        srcreg1_num = rs1_s;
        srcreg2_num = rs2_s;
        imm         = imm_s_s;
        aluop1_type = OP_TYPE_REG;
        aluop2_type = OP_TYPE_IMM;
        is_store    = 1'b1;
        case (funct3_s)
          3'b000:  alucode = ALU_SB;
          3'b001:  alucode = ALU_SH;
          3'b010:  alucode = ALU_SW;
          default: legal_s = 1'b0;
        endcase
      end
      OPC_BRANCH: begin
        srcreg1_num = rs1_s;
        srcreg2_num = rs2_s;
        imm         = imm_b_s;
        aluop1_type = OP_TYPE_REG;
        aluop2_type = OP_TYPE_REG;
        case (funct3_s)
          3'b000:  alucode = ALU_BEQ;
          3'b001:  alucode = ALU_BNE;
          3'b100:  alucode = ALU_BLT;
          3'b101:  alucode = ALU_BGE;
          3'b110:  alucode = ALU_BLTU;
          3'b111:  alucode = ALU_BGEU;
          default: legal_s = 1'b0;
        endcase
      end
      OPC_JAL: begin
        dstreg_num  = rd_s;
        imm         = imm_j_s;
        alucode     = ALU_JAL;
        aluop2_type = OP_TYPE_PC;
        writes_s    = 1'b1;
      end
      OPC_JALR: begin
        srcreg1_num = rs1_s;
        dstreg_num  = rd_s;
        imm         = imm_i_s;
        alucode     = ALU_JALR;
        aluop1_type = OP_TYPE_REG;
        aluop2_type = OP_TYPE_PC;
        writes_s    = 1'b1;
        legal_s     = (funct3_s == 3'b000);
      end
      default: legal_s = 1'b0;
    endcase
    if (!legal_s) begin
      srcreg1_num = 5'd0;
      srcreg2_num = 5'd0;
      dstreg_num  = 5'd0;
      imm         = 32'd0;
      alucode     = ALU_NOP;
      aluop1_type = OP_TYPE_NONE;
      aluop2_type = OP_TYPE_NONE;
      is_load     = 1'b0;
      is_store    = 1'b0;
      writes_s    = 1'b0;
    end else begin
      writes_s    = writes_s;
    end
    // Writes to x0 are discarded, so never request them
    reg_we = writes_s && (dstreg_num != 5'd0);
  end

  // Halt becomes sticky once ECALL is seen
  always_comb begin
    halt_d = halt_q | (ir == ECALL);
  end

  // Halt flag register with synchronous active-low reset (reset beats ECALL)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign is_halt = halt_q;

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares every output field.
module tb_decoder;

  localparam logic [5:0] A_LUI = 6'd0, A_JAL = 6'd1, A_JALR = 6'd2, A_BEQ = 6'd3;
  localparam logic [5:0] A_LBU = 6'd12, A_LW = 6'd11, A_SH = 6'd15, A_ADD = 6'd17;
  localparam logic [5:0] A_SUB = 6'd18, A_XOR = 6'd19, A_SRA = 6'd26, A_NOP = 6'd63;
  localparam logic [5:0] A_BLTU = 6'd7;
  localparam logic [1:0] T_N = 2'd0, T_R = 2'd1, T_I = 2'd2, T_P = 2'd3;

  typedef struct packed {
    logic [31:0] ir;
    logic        rst_n;
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic [1:0]  t1;
    logic [1:0]  t2;
    logic        we;
    logic        ld;
    logic        st;
    logic        halt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ir;
  logic [4:0]  srcreg1_num, srcreg2_num, dstreg_num;
  logic [31:0] imm;
  logic [5:0]  alucode;
  logic [1:0]  aluop1_type, aluop2_type;
  logic        reg_we, is_load, is_store, is_halt;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t exp_q[$];
  vec_t vecs[$];

  decoder dut (
    .clk(clk), .rst_n(rst_n), .ir(ir),
    .srcreg1_num(srcreg1_num), .srcreg2_num(srcreg2_num), .dstreg_num(dstreg_num),
    .imm(imm), .alucode(alucode), .aluop1_type(aluop1_type), .aluop2_type(aluop2_type),
    .reg_we(reg_we), .is_load(is_load), .is_store(is_store), .is_halt(is_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] ir_v,
                       input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s ir=%08h got=%0h expected=%0h", name, ir_v, act, exp_v);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      e = exp_q.pop_front();
      check("src1",   e.ir, {27'd0, srcreg1_num}, {27'd0, e.s1});
      check("src2",   e.ir, {27'd0, srcreg2_num}, {27'd0, e.s2});
      check("dst",    e.ir, {27'd0, dstreg_num},  {27'd0, e.d});
      check("imm",    e.ir, imm,                  e.imm);
      check("alu",    e.ir, {26'd0, alucode},     {26'd0, e.alu});
      check("op1",    e.ir, {30'd0, aluop1_type}, {30'd0, e.t1});
      check("op2",    e.ir, {30'd0, aluop2_type}, {30'd0, e.t2});
      check("reg_we", e.ir, {31'd0, reg_we},      {31'd0, e.we});
      check("load",   e.ir, {31'd0, is_load},     {31'd0, e.ld});
      check("store",  e.ir, {31'd0, is_store},    {31'd0, e.st});
      check("halt",   e.ir, {31'd0, is_halt},     {31'd0, e.halt});
    end
  end

  function automatic vec_t mk(input logic [31:0] i, input logic r,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                              input logic [31:0] im, input logic [5:0] a,
                              input logic [1:0] t1, input logic [1:0] t2,
                              input logic we, input logic ld, input logic st, input logic h);
    vec_t v;
    v = '{ir: i, rst_n: r, s1: s1, s2: s2, d: d, imm: im, alu: a, t1: t1, t2: t2,
          we: we, ld: ld, st: st, halt: h};
    return v;
  endfunction

  initial begin
    // ir, rst_n, src1, src2, dst, imm, alu, op1, op2, we, ld, st, halt (after this cycle's edge)
    vecs.push_back(mk(32'h0000_0000, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        A_NOP,  T_N, T_N, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h40b6_0633, 1'b1, 5'd12, 5'd11, 5'd12, 32'h0,        A_SUB,  T_R, T_R, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00c5_c533, 1'b1, 5'd11, 5'd12, 5'd10, 32'h0,        A_XOR,  T_R, T_R, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'hfff0_0513, 1'b1, 5'd0,  5'd0,  5'd10, 32'hffffffff, A_ADD,  T_R, T_I, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h4015_d793, 1'b1, 5'd11, 5'd0,  5'd15, 32'h1,        A_SRA,  T_R, T_I, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h8088_05b7, 1'b1, 5'd0,  5'd0,  5'd11, 32'h80880000, A_LUI,  T_N, T_I, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0817, 1'b1, 5'd0,  5'd0,  5'd16, 32'h0,        A_ADD,  T_I, T_P, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00b5_10a3, 1'b1, 5'd10, 5'd11, 5'd0,  32'h1,        A_SH,   T_R, T_I, 1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(32'h0035_4683, 1'b1, 5'd10, 5'd0,  5'd13, 32'h3,        A_LBU,  T_R, T_I, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'hffc5_2503, 1'b1, 5'd10, 5'd0,  5'd10, 32'hfffffffc, A_LW,   T_R, T_I, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(32'hfec5_84e3, 1'b1, 5'd11, 5'd12, 5'd0,  32'hffffffe8, A_BEQ,  T_R, T_R, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00c5_e463, 1'b1, 5'd11, 5'd12, 5'd0,  32'h8,        A_BLTU, T_R, T_R, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00c0_006f, 1'b1, 5'd0,  5'd0,  5'd0,  32'hc,        A_JAL,  T_N, T_P, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0085_80e7, 1'b1, 5'd11, 5'd0,  5'd1,  32'h8,        A_JALR, T_R, T_P, 1'b1, 1'b0, 1'b0, 1'b0));
    // illegal: load funct3 011, store funct3 011, branch funct3 010, FENCE
    vecs.push_back(mk(32'h0035_3683, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        A_NOP,  T_N, T_N, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00b5_30a3, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        A_NOP,  T_N, T_N, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h00c5_a463, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        A_NOP,  T_N, T_N, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0ff0_000f, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        A_NOP,  T_N, T_N, 1'b0, 1'b0, 1'b0, 1'b0));
    // halt sequence: ECALL under reset (reset wins), then ECALL, NOPs, reset
    vecs.push_back(mk(32'h0000_0073, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        A_NOP,  T_N, T_N, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0013, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        A_ADD,  T_R, T_I, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0073, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        A_NOP,  T_N, T_N, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0013, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        A_ADD,  T_R, T_I, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'h0000_0013, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        A_ADD,  T_R, T_I, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'h0000_0013, 1'b0, 5'd0,  5'd0,  5'd0,  32'h0,        A_ADD,  T_R, T_I, 1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(32'h0000_0013, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        A_ADD,  T_R, T_I, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(32'h0000_0013, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        A_ADD,  T_R, T_I, 1'b0, 1'b0, 1'b0, 1'b0));

    rst_n = 1'b0;
    ir    = 32'h0000_0000;
    foreach (vecs[k]) begin
      @(posedge clk);
      #1;
      rst_n = vecs[k].rst_n;
      ir    = vecs[k].ir;
      exp_q.push_back(vecs[k]);
    end

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) begin
      @(posedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
